// File: rtl/line_step_sequencer_pkg.sv
// Shared types for the line step sequencer: FSM state encoding and default operand width.
package line_step_sequencer_pkg;

  localparam int LSS_NUM_BITS_DEFAULT = 16;

  typedef enum logic [2:0] {
    LSS_IDLE    = 3'd0,
    LSS_CALC    = 3'd1,
    LSS_TRIGGER = 3'd2,
    LSS_WAIT    = 3'd3,
    LSS_FINISH  = 3'd4
  } line_step_seq_state_t;

endpackage

// File: rtl/bresenham_step_calc.sv
// One Bresenham iteration: decides which axes step this iteration and the updated error term.
module bresenham_step_calc
  import line_step_sequencer_pkg::*;
#(
  parameter int NUM_BITS = LSS_NUM_BITS_DEFAULT
) (
  input  logic signed [NUM_BITS+1:0] err,
  input  logic        [NUM_BITS-1:0] adx,
  input  logic        [NUM_BITS-1:0] ady,
  output logic                       step_x,
  output logic                       step_y,
  output logic signed [NUM_BITS+1:0] err_next
);

  localparam int EW = NUM_BITS + 2;

  logic signed [EW-1:0] w_e2;
  logic signed [EW-1:0] w_adx;
  logic signed [EW-1:0] w_ady;
  logic signed [EW-1:0] w_add;
  logic signed [EW-1:0] w_sub;

  // err stays within [-ady, adx], so doubling it cannot overflow EW bits
  assign w_e2     = {err[EW-2:0], 1'b0};
  assign w_adx    = $signed({2'b00, adx});
  assign w_ady    = $signed({2'b00, ady});
  assign step_x   = (w_e2 > -w_ady);
  assign step_y   = (w_e2 < w_adx);
  assign w_add    = step_y ? w_adx : {EW{1'b0}};
  assign w_sub    = step_x ? w_ady : {EW{1'b0}};
  assign err_next = err + w_add - w_sub;

endmodule

// File: rtl/line_step_sequencer.sv
// Bresenham line sequencer: issues one trigger per axis per iteration and waits for both
// stepper controllers to go idle before computing the next iteration.
module line_step_sequencer
  import line_step_sequencer_pkg::*;
#(
  parameter int NUM_BITS = LSS_NUM_BITS_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_en,
  input  logic                start,
  input  logic [NUM_BITS-1:0] dx,
  input  logic [NUM_BITS-1:0] dy,
  input  logic                x_working,
  input  logic                y_working,
  output logic                x_trigger,
  output logic                y_trigger,
  output logic                x_dir,
  output logic                y_dir,
  output logic                busy,
  output logic                done
);

  localparam int EW = NUM_BITS + 2;
  localparam logic [NUM_BITS-1:0] ONE  = {{(NUM_BITS-1){1'b0}}, 1'b1};
  localparam logic [NUM_BITS-1:0] ZERO = {NUM_BITS{1'b0}};

  line_step_seq_state_t r_state;
  logic [NUM_BITS-1:0]  r_adx;
  logic [NUM_BITS-1:0]  r_ady;
  logic [NUM_BITS-1:0]  r_iter;
  logic signed [EW-1:0] r_err;
  logic                 r_x_trigger;
  logic                 r_y_trigger;
  logic                 r_x_dir;
  logic                 r_y_dir;
  logic                 r_busy;
  logic                 r_done;

  logic [NUM_BITS-1:0]  w_adx_in;
  logic [NUM_BITS-1:0]  w_ady_in;
  logic [NUM_BITS-1:0]  w_iter_init;
  logic signed [EW-1:0] w_err_init;
  logic                 w_step_x;
  logic                 w_step_y;
  logic signed [EW-1:0] w_err_next;

  // Unsigned magnitude keeps |-2^(N-1)| representable as 2^(N-1)
  assign w_adx_in    = dx[NUM_BITS-1] ? (~dx + ONE) : dx;
  assign w_ady_in    = dy[NUM_BITS-1] ? (~dy + ONE) : dy;
  assign w_iter_init = (w_adx_in > w_ady_in) ? w_adx_in : w_ady_in;
  assign w_err_init  = $signed({2'b00, w_adx_in}) - $signed({2'b00, w_ady_in});

  bresenham_step_calc #(
    .NUM_BITS (NUM_BITS)
  ) u_step_calc (
    .err      (r_err),
    .adx      (r_adx),
    .ady      (r_ady),
    .step_x   (w_step_x),
    .step_y   (w_step_y),
    .err_next (w_err_next)
  );

  // Sequencer FSM with registered Moore outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= LSS_IDLE;
      r_adx       <= ZERO;
      r_ady       <= ZERO;
      r_iter      <= ZERO;
      r_err       <= {EW{1'b0}};
      r_x_trigger <= 1'b0;
      r_y_trigger <= 1'b0;
      r_x_dir     <= 1'b0;
      r_y_dir     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (clk_en) begin
      case (r_state)
        LSS_IDLE: begin
          if (start) begin
            r_adx   <= w_adx_in;
            r_ady   <= w_ady_in;
            r_iter  <= w_iter_init;
            r_err   <= w_err_init;
            r_x_dir <= dx[NUM_BITS-1];
            r_y_dir <= dy[NUM_BITS-1];
            r_busy  <= 1'b1;
            r_state <= LSS_CALC;
          end
        end
        LSS_CALC: begin
          if (r_iter == ZERO) begin
            r_done  <= 1'b1;
            r_state <= LSS_FINISH;
          end else begin
            r_x_trigger <= w_step_x;
            r_y_trigger <= w_step_y;
            r_err       <= w_err_next;
            r_iter      <= r_iter - ONE;
            r_state     <= LSS_TRIGGER;
          end
        end
        LSS_TRIGGER: begin
          r_x_trigger <= 1'b0;
          r_y_trigger <= 1'b0;
          r_state     <= LSS_WAIT;
        end
        LSS_WAIT: begin
          if (!x_working && !y_working) begin
            r_state <= LSS_CALC;
          end
        end
        LSS_FINISH: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= LSS_IDLE;
        end
        default: begin
          r_x_trigger <= 1'b0;
          r_y_trigger <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_state     <= LSS_IDLE;
        end
      endcase
    end
  end

  assign x_trigger = r_x_trigger;
  assign y_trigger = r_y_trigger;
  assign x_dir     = r_x_dir;
  assign y_dir     = r_y_dir;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_line_step_sequencer.sv
// Directed bench for line_step_sequencer with a simple stepper-controller model.
module tb_line_step_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_en = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dx = 16'd0;
  logic [15:0] dy = 16'd0;
  logic        x_working = 1'b0;
  logic        y_working = 1'b0;
  logic        x_trigger, y_trigger, x_dir, y_dir, busy, done;

  int tests = 0;
  int fails = 0;

  int x_hold = 0;
  int y_hold = 0;
  int x_cnt = 0;
  int y_cnt = 0;

  int cyc = 0;
  int xp = 0;
  int yp = 0;
  int dp = 0;
  int viol = 0;
  logic [1:0] plog[$];
  int         pcyc[$];

  always #5 clk = ~clk;

  line_step_sequencer #(.NUM_BITS(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .start     (start),
    .dx        (dx),
    .dy        (dy),
    .x_working (x_working),
    .y_working (y_working),
    .x_trigger (x_trigger),
    .y_trigger (y_trigger),
    .x_dir     (x_dir),
    .y_dir     (y_dir),
    .busy      (busy),
    .done      (done)
  );

  // Stepper model: a trigger makes the axis busy for x_hold/y_hold cycles
  always @(posedge clk) begin
    if (clk_en) begin
      if (x_trigger && x_hold > 0) begin
        x_working <= 1'b1;
        x_cnt     <= x_hold;
      end else if (x_cnt > 1) begin
        x_cnt <= x_cnt - 1;
      end else begin
        x_cnt     <= 0;
        x_working <= 1'b0;
      end
      if (y_trigger && y_hold > 0) begin
        y_working <= 1'b1;
        y_cnt     <= y_hold;
      end else if (y_cnt > 1) begin
        y_cnt <= y_cnt - 1;
      end else begin
        y_cnt     <= 0;
        y_working <= 1'b0;
      end
    end
  end

  // Pulse monitor sampled on the falling edge
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (clk_en) begin
      if (x_trigger) xp <= xp + 1;
      if (y_trigger) yp <= yp + 1;
      if (done) dp <= dp + 1;
      if (x_trigger || y_trigger) begin
        plog.push_back({x_trigger, y_trigger});
        pcyc.push_back(cyc);
      end
      if ((x_trigger && x_working) || (y_trigger && y_working)) viol <= viol + 1;
    end
  end

  task automatic do_start(input logic [15:0] mdx, input logic [15:0] mdy);
    @(negedge clk);
    dx = mdx;
    dy = mdy;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dx = 16'h5A5A;
    dy = 16'hA5A5;
  endtask

  task automatic wait_done(input string name, input int budget);
    int ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    tests++;
    if (ok !== 1) begin
      fails++;
      $display("FAIL %s: done not seen within %0d cycles (got %0d, want 1)", name, budget, ok);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if ({x_trigger, y_trigger, x_dir, y_dir, busy, done} !== 6'b000000) begin
      fails++;
      $display("FAIL reset_outputs: got %b want 000000",
               {x_trigger, y_trigger, x_dir, y_dir, busy, done});
    end
    reset = 1'b0;
  endtask

  task automatic test_x_only;
    int bx, by, bd;
    bx = xp; by = yp; bd = dp;
    do_start(16'd3, 16'd0);
    tests++;
    if ({busy, x_dir} !== 2'b10) begin
      fails++;
      $display("FAIL x_only_start: busy,x_dir got %b want 10", {busy, x_dir});
    end
    wait_done("x_only_done", 40);
    @(negedge clk);
    tests++;
    if ({busy, done} !== 2'b00) begin
      fails++;
      $display("FAIL x_only_idle: busy,done got %b want 00", {busy, done});
    end
    tests++;
    if ((xp - bx) !== 3 || (yp - by) !== 0 || (dp - bd) !== 1) begin
      fails++;
      $display("FAIL x_only_counts: x=%0d y=%0d done=%0d want 3 0 1", xp - bx, yp - by, dp - bd);
    end
  endtask

  task automatic test_diag_2_1;
    int b;
    logic [3:0] pat;
    b = plog.size();
    do_start(16'd2, 16'd1);
    wait_done("diag_done", 40);
    @(negedge clk);
    pat = {plog[b], plog[b+1]};
    tests++;
    if (plog.size() - b !== 2 || pat !== 4'b1011) begin
      fails++;
      $display("FAIL diag_pattern: n=%0d pat=%b want n=2 pat=1011", plog.size() - b, pat);
    end
    tests++;
    if (dut.r_err !== 18'sd1) begin
      fails++;
      $display("FAIL diag_final_err: got %0d want 1", dut.r_err);
    end
  endtask

  task automatic test_negative;
    int b, bx, by;
    logic [5:0] pat;
    b = plog.size(); bx = xp; by = yp;
    do_start(16'hFFFF, 16'hFFFD);
    tests++;
    if ({x_dir, y_dir} !== 2'b11) begin
      fails++;
      $display("FAIL neg_dirs: got %b want 11", {x_dir, y_dir});
    end
    wait_done("neg_done", 40);
    @(negedge clk);
    pat = {plog[b], plog[b+1], plog[b+2]};
    tests++;
    if (plog.size() - b !== 3 || pat !== 6'b011101) begin
      fails++;
      $display("FAIL neg_pattern: n=%0d pat=%b want n=3 pat=011101", plog.size() - b, pat);
    end
    tests++;
    if ((xp - bx) !== 1 || (yp - by) !== 3) begin
      fails++;
      $display("FAIL neg_counts: x=%0d y=%0d want 1 3", xp - bx, yp - by);
    end
  endtask

  task automatic test_zero_move;
    int bx, by, bd;
    bx = xp; by = yp; bd = dp;
    do_start(16'd0, 16'd0);
    wait_done("zero_done", 3);
    @(negedge clk);
    tests++;
    if ((xp - bx) !== 0 || (yp - by) !== 0 || (dp - bd) !== 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL zero_move: x=%0d y=%0d done=%0d busy=%b want 0 0 1 0",
               xp - bx, yp - by, dp - bd, busy);
    end
  endtask

  task automatic test_slow_stepper;
    int b, bx, bv, gap;
    b = plog.size(); bx = xp; bv = viol;
    x_hold = 10;
    do_start(16'd2, 16'd0);
    for (int i = 0; i < 20 && !x_working; i++) @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    dx = 16'hFFFB;
    @(negedge clk);
    start = 1'b0;
    wait_done("slow_done", 60);
    @(negedge clk);
    gap = pcyc[b+1] - pcyc[b];
    tests++;
    if (plog.size() - b !== 2 || gap !== 13) begin
      fails++;
      $display("FAIL slow_gap: n=%0d gap=%0d want n=2 gap=13", plog.size() - b, gap);
    end
    tests++;
    if ((xp - bx) !== 2 || x_dir !== 1'b0 || (viol - bv) !== 0) begin
      fails++;
      $display("FAIL slow_ignore_start: x=%0d dir=%b viol=%0d want 2 0 0", xp - bx, x_dir, viol - bv);
    end
    x_hold = 0;
  endtask

  task automatic test_clk_en_freeze;
    int bx;
    bx = xp;
    do_start(16'd2, 16'd0);
    for (int i = 0; i < 10 && !x_trigger; i++) @(negedge clk);
    #2 clk_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if ({x_trigger, busy, x_dir} !== 3'b110) begin
        fails++;
        $display("FAIL freeze_%0d: trig,busy,dir got %b want 110", i, {x_trigger, busy, x_dir});
      end
    end
    #2 clk_en = 1'b1;
    wait_done("freeze_done", 40);
    @(negedge clk);
    tests++;
    if ((xp - bx) !== 2) begin
      fails++;
      $display("FAIL freeze_pulses: got %0d want 2", xp - bx);
    end
  endtask

  task automatic test_reset_mid_move;
    int b;
    x_hold = 10;
    do_start(16'd5, 16'd0);
    for (int i = 0; i < 20 && !x_working; i++) @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({x_trigger, y_trigger, x_dir, y_dir, busy, done} !== 6'b000000) begin
      fails++;
      $display("FAIL reset_mid: got %b want 000000",
               {x_trigger, y_trigger, x_dir, y_dir, busy, done});
    end
    reset = 1'b0;
    x_hold = 0;
    for (int i = 0; i < 20 && x_working; i++) @(negedge clk);
    b = plog.size();
    do_start(16'd1, 16'd1);
    wait_done("after_reset_done", 20);
    @(negedge clk);
    tests++;
    if (plog.size() - b !== 1 || plog[b] !== 2'b11) begin
      fails++;
      $display("FAIL after_reset_pattern: n=%0d pat=%b want n=1 pat=11", plog.size() - b, plog[b]);
    end
  endtask

  initial begin
    test_reset();
    test_x_only();
    test_diag_2_1();
    test_negative();
    test_zero_move();
    test_slow_stepper();
    test_clk_en_freeze();
    test_reset_mid_move();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
